apb_req_arbiter: RTL and testbench
==================================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface -- parameters
REQ-001 SHALL provide ADDR_W, default 8, APB address width.
REQ-002 SHALL provide DATA_W, default 32, APB data width.
REQ-003 SHALL provide TIMEOUT, default 16, max ACCESS cycles without PREADY; 0 disables timeout.

Interface -- ports
REQ-004 SHALL have PCLK  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have PRESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have req_valid  input  2  per-requester request pending.
REQ-007 SHALL have req_write  input  2  per-requester write (1) / read (0).
REQ-008 SHALL have req_addr  input  2*ADDR_W  per-requester address, requester i in slice i.
REQ-009 SHALL have req_wdata  input  2*DATA_W  per-requester write data, requester i in slice i.
REQ-010 SHALL have req_ready  output  2  one-hot accept pulse, request captured that cycle.
REQ-011 SHALL have rsp_valid  output  2  one-hot one-cycle completion pulse.
REQ-012 SHALL have rsp_rdata  output  DATA_W  shared read data, valid with rsp_valid.
REQ-013 SHALL have rsp_err  output  1  shared error flag, valid with rsp_valid.
REQ-014 SHALL have PSEL, PENABLE, PWRITE  output  1 each  APB control to slave.
REQ-015 SHALL have PADDR  output  ADDR_W; PWDATA  output  DATA_W  APB address/write data.
REQ-016 SHALL have PRDATA  input  DATA_W; PREADY  input  1; PSLVERR  input  1  APB slave response.

Function
REQ-017 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE; no other states.
REQ-018 SHALL, in IDLE with any req_valid set, pick grant g, assert req_ready[g] combinationally that cycle, capture req_write/addr/wdata[g] into PWRITE/PADDR/PWDATA, go to SETUP.
REQ-019 SHALL arbitrate round-robin: single valid wins; both valid -> requester != last_grant wins; last_grant updates on every accept.
REQ-020 SHALL drive PSEL=1, PENABLE=0 in SETUP, then unconditionally enter ACCESS next cycle.
REQ-021 SHALL drive PSEL=1, PENABLE=1 in ACCESS; PADDR/PWRITE/PWDATA stable from SETUP until ACCESS completes.
REQ-022 SHALL complete ACCESS on the first cycle PREADY=1: register rsp_rdata=PRDATA (0 for writes), rsp_err=PSLVERR, pulse rsp_valid[g] next cycle, return to IDLE.
REQ-023 SHALL count ACCESS cycles with PREADY=0 in a counter of width clog2(TIMEOUT+1); on reaching TIMEOUT (TIMEOUT>0), complete with rsp_err=1, rsp_rdata=0, return to IDLE.
REQ-024 SHALL clear the timeout counter on entry to SETUP.
REQ-025 SHALL drive PSEL=0, PENABLE=0 in IDLE; PADDR/PWDATA/PWRITE hold last values.
REQ-026 SHALL accept a new request in the IDLE cycle coinciding with the rsp_valid pulse; minimum transfer period 3 cycles.
REQ-027 SHALL ignore req_valid changes outside IDLE; never assert req_ready outside IDLE.
REQ-028 SHALL keep rsp_rdata/rsp_err holding their last value when rsp_valid=0.

Reset
REQ-029 SHALL on PRESET=1 immediately force state=IDLE, PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0, last_grant=1 (requester 0 wins first tie).
REQ-030 SHALL abort an in-flight transfer on reset without any rsp_valid; requester reissues after release.
REQ-031 SHALL leave FSM in IDLE on the first PCLK edge after PRESET deasserts, accepting requests from that cycle.

Verification
REQ-032 SHALL cover read, req0, addr 0x10, PREADY=1 immediately, PRDATA=0xDEADBEEF -> req_ready[0] cycle 0, PSEL cycle 1, PENABLE cycle 2, rsp_valid[0]=1 cycle 3 with rdata 0xDEADBEEF, err 0.
REQ-033 SHALL cover both req_valid held high after reset for 4 transfers -> grant order 0,1,0,1.
REQ-034 SHALL cover write, req1, PREADY low 3 ACCESS cycles, PSLVERR=1 on completion -> PADDR/PWDATA stable throughout, rsp_valid[1] with err=1.
REQ-035 SHALL cover PREADY stuck 0, TIMEOUT=16 -> ACCESS lasts exactly 16 cycles, rsp_err=1, rsp_rdata=0, FSM back in IDLE.
REQ-036 SHALL cover PRESET asserted mid-ACCESS -> PSEL/PENABLE 0 same cycle, no rsp_valid, next grant goes to requester 0 on tie.

Source files
------------

// File: rtl/apb_req_arbiter_if.sv
// ----------------------------------------------------------------------------
// apb_req_arbiter_if
//
// Purpose: bundles the two-requester request/response handshake and the APB
// master-side bus of the arbiter into one interface.
//
// Signal summary:
//   req_valid [1:0]         per-requester request pending
//   req_write [1:0]         per-requester write (1) / read (0)
//   req_addr  [2*ADDR_W]    requester i address in slice i
//   req_wdata [2*DATA_W]    requester i write data in slice i
//   req_ready [1:0]         one-hot accept pulse
//   rsp_valid [1:0]         one-hot completion pulse
//   rsp_rdata [DATA_W]      shared read data, valid with rsp_valid
//   rsp_err                 shared error flag, valid with rsp_valid
//   PSEL/PENABLE/PWRITE     APB control towards the slave
//   PADDR/PWDATA            APB address / write data
//   PRDATA/PREADY/PSLVERR   APB slave response
//
// Modports:
//   master - the arbiter (drives APB, consumes requests)
//   slave  - the environment (requesters plus APB slave)
// ----------------------------------------------------------------------------
interface apb_req_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [1:0]          req_valid;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          req_ready;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic                PSEL;
    logic                PENABLE;
    logic                PWRITE;
    logic [ADDR_W-1:0]   PADDR;
    logic [DATA_W-1:0]   PWDATA;
    logic [DATA_W-1:0]   PRDATA;
    logic                PREADY;
    logic                PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// ----------------------------------------------------------------------------
// apb_req_arbiter
//
// Purpose: round-robin arbiter that lets two requesters share one APB master
// port. A request is accepted in IDLE, then walked through SETUP and ACCESS;
// the completion (data + error) is returned to the granted requester as a
// one-cycle pulse. An ACCESS phase that waits too long for PREADY is
// terminated with an error.
//
// Ports:
//   PCLK    sole clock, rising edge
//   PRESET  asynchronous active-high reset
//   bus     apb_req_arbiter_if.master: request/response handshake + APB bus
//
// Parameters:
//   ADDR_W   APB address width
//   DATA_W   APB data width
//   TIMEOUT  max ACCESS cycles without PREADY; 0 disables the timeout
// ----------------------------------------------------------------------------
module apb_req_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    apb_req_arbiter_if.master bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    // A zero TIMEOUT would give a zero-width counter, so keep at least 1 bit.
    localparam int               CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    logic [1:0]        state_q,     state_d;
    logic              lastGrant_q, lastGrant_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic [1:0]        rspValid_q,  rspValid_d;
    logic [DATA_W-1:0] rspRdata_q,  rspRdata_d;
    logic              rspErr_q,    rspErr_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;

    logic              grant;
    logic [1:0]        reqReady;
    logic [CNT_W-1:0]  cntInc;
    logic [1:0]        grantOneHot;

    // Round-robin pick: a lone requester wins outright; on a tie the one that
    // was not granted last time wins. For 2'b01 this gives 0, for 2'b10 gives 1.
    always_comb begin
        grant = (bus.req_valid == 2'b11) ? ~lastGrant_q : bus.req_valid[1];
    end

    // lastGrant_q is updated on every accept, so during a transfer it names
    // the requester that owns the response.
    assign grantOneHot = lastGrant_q ? 2'b10 : 2'b01;

    // Next-state logic for the transfer FSM and its datapath registers.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rspValid_d  = 2'b00;
        rspRdata_d  = rspRdata_q;
        rspErr_d    = rspErr_q;
        cnt_d       = cnt_q;
        reqReady    = 2'b00;
        cntInc      = cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    reqReady    = grant ? 2'b10 : 2'b01;
                    lastGrant_d = grant;
                    pwrite_d    = bus.req_write[grant];
                    paddr_d     = grant ? bus.req_addr[2*ADDR_W-1:ADDR_W]
                                        : bus.req_addr[ADDR_W-1:0];
                    pwdata_d    = grant ? bus.req_wdata[2*DATA_W-1:DATA_W]
                                        : bus.req_wdata[DATA_W-1:0];
                    cnt_d       = '0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    rspValid_d = grantOneHot;
                    rspRdata_d = pwrite_q ? '0 : bus.PRDATA;
                    rspErr_d   = bus.PSLVERR;
                    state_d    = IDLE;
                end else if ((TIMEOUT > 0) && (cntInc == CNT_LIMIT)) begin
                    // This was the TIMEOUT-th cycle without PREADY.
                    rspValid_d = grantOneHot;
                    rspRdata_d = '0;
                    rspErr_d   = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cntInc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transfer without a response.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rspValid_q  <= 2'b00;
            rspRdata_q  <= '0;
            rspErr_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rspValid_q  <= rspValid_d;
            rspRdata_q  <= rspRdata_d;
            rspErr_q    <= rspErr_d;
            cnt_q       <= cnt_d;
        end
    end

    // PSEL/PENABLE are decoded from state so reset drops them immediately.
    assign bus.req_ready = reqReady;
    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_rdata = rspRdata_q;
    assign bus.rsp_err   = rspErr_q;
    assign bus.PSEL      = (state_q != IDLE);
    assign bus.PENABLE   = (state_q == ACCESS);
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_apb_req_arbiter
//
// Purpose: self-checking bench for apb_req_arbiter. A driver issues one cycle
// of requester stimulus at a time and, whenever the reference model predicts
// an accept, pushes the expected response into a scoreboard queue and the
// slave behaviour into a plan queue. A monitor pops and compares whenever the
// DUT pulses rsp_valid. An APB slave model replays the planned wait states.
// ----------------------------------------------------------------------------
module tb_apb_req_arbiter;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic              g;
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                rspCycle;
    } rsp_t;

    typedef struct packed {
        int unsigned       w;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } plan_t;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b0;

    apb_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_req_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus)
    );

    always #5 PCLK = ~PCLK;

    rsp_t  expQ[$];
    plan_t planQ[$];
    int    grantLog[$];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model state
    int                lastGrant  = 1;
    int                busyUntil  = 0;
    int                acceptCycle = -10;
    logic              expPwrite  = 1'b0;
    logic [ADDR_W-1:0] expPaddr   = '0;
    logic [DATA_W-1:0] expPwdata  = '0;
    logic [DATA_W-1:0] holdRdata  = '0;
    logic              holdErr    = 1'b0;

    // Slave model state
    plan_t       slvPlan;
    int unsigned accessN = 0;

    always @(posedge PCLK) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    function automatic logic [1:0] oneHot(input int g);
        return (g != 0) ? 2'b10 : 2'b01;
    endfunction

    // Round-robin rule: a lone requester wins; on a tie the other one than last time.
    function automatic int pickGrant(input logic [1:0] mask);
        if (mask == 2'b11) return (lastGrant == 0) ? 1 : 0;
        return mask[1] ? 1 : 0;
    endfunction

    // One clock cycle of stimulus plus the cycle-level bus checks.
    task automatic applyStimulus(input logic [1:0] mask, input logic [1:0] wr,
                                 input logic [2*ADDR_W-1:0] addr,
                                 input logic [2*DATA_W-1:0] wdata,
                                 input int unsigned planW,
                                 input logic [DATA_W-1:0] planRdata,
                                 input logic planErr);
        logic [1:0] expReady;
        logic       expPsel;
        logic       expPen;
        logic       timedOut;
        int         g;
        int         accessLen;
        plan_t      p;
        rsp_t       r;

        @(posedge PCLK);
        #1;
        bus.req_valid = mask;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(negedge PCLK);

        expPsel = (cycle > acceptCycle) && (cycle < busyUntil);
        expPen  = (cycle > acceptCycle + 1) && (cycle < busyUntil);
        checkOutput("PSEL",    64'(bus.PSEL),    64'(expPsel));
        checkOutput("PENABLE", 64'(bus.PENABLE), 64'(expPen));
        checkOutput("PWRITE",  64'(bus.PWRITE),  64'(expPwrite));
        checkOutput("PADDR",   64'(bus.PADDR),   64'(expPaddr));
        checkOutput("PWDATA",  64'(bus.PWDATA),  64'(expPwdata));

        expReady = 2'b00;
        g        = 0;
        if (cycle >= busyUntil && mask != 2'b00) begin
            g        = pickGrant(mask);
            expReady = oneHot(g);
        end
        checkOutput("req_ready", 64'(bus.req_ready), 64'(expReady));

        if (expReady != 2'b00) begin
            lastGrant   = g;
            acceptCycle = cycle;
            expPwrite   = wr[g];
            expPaddr    = (g != 0) ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
            expPwdata   = (g != 0) ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
            timedOut    = (TIMEOUT > 0) && (planW >= TIMEOUT);
            accessLen   = timedOut ? TIMEOUT : int'(planW) + 1;
            busyUntil   = cycle + 2 + accessLen;
            p.w         = planW;
            p.rdata     = planRdata;
            p.err       = planErr;
            planQ.push_back(p);
            r.g         = (g != 0);
            r.rdata     = (timedOut || wr[g]) ? '0 : planRdata;
            r.err       = timedOut ? 1'b1 : planErr;
            r.rspCycle  = busyUntil;
            expQ.push_back(r);
            grantLog.push_back(g);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(2'b00, 2'(($urandom)), 16'($urandom), {$urandom, $urandom},
                                 0, '0, 1'b0);
    endtask

    // Runs idle cycles until the in-flight transfer has responded.
    task automatic drain();
        int guard = 0;
        while (cycle <= busyUntil && guard < 100) begin
            idleCycles(1);
            guard++;
        end
    endtask

    // Asserts reset mid-cycle, checks the outputs drop at once, clears the model.
    task automatic doReset();
        @(posedge PCLK);
        #2;
        PRESET        = 1'b1;
        bus.req_valid = 2'b00;
        expQ.delete();
        planQ.delete();
        lastGrant   = 1;
        busyUntil   = 0;
        acceptCycle = -10;
        expPwrite   = 1'b0;
        expPaddr    = '0;
        expPwdata   = '0;
        holdRdata   = '0;
        holdErr     = 1'b0;
        #1;
        checkOutput("rst_PSEL",      64'(bus.PSEL),      64'(0));
        checkOutput("rst_PENABLE",   64'(bus.PENABLE),   64'(0));
        checkOutput("rst_PWRITE",    64'(bus.PWRITE),    64'(0));
        checkOutput("rst_PADDR",     64'(bus.PADDR),     64'(0));
        checkOutput("rst_PWDATA",    64'(bus.PWDATA),    64'(0));
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        checkOutput("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
        checkOutput("rst_rsp_err",   64'(bus.rsp_err),   64'(0));
        checkOutput("rst_req_ready", 64'(bus.req_ready), 64'(0));
        repeat (2) @(posedge PCLK);
        #2;
        PRESET = 1'b0;
    endtask

    // Scoreboard monitor: compares every response pulse and checks hold otherwise.
    always @(negedge PCLK) begin
        rsp_t e;
        if (expQ.size() > 0 && expQ[0].rspCycle == cycle) begin
            e = expQ.pop_front();
            checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(oneHot(int'(e.g))));
            checkOutput("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
            checkOutput("rsp_err",   64'(bus.rsp_err),   64'(e.err));
            holdRdata = e.rdata;
            holdErr   = e.err;
        end else begin
            checkOutput("rsp_valid_quiet", 64'(bus.rsp_valid), 64'(0));
            checkOutput("rsp_rdata_hold",  64'(bus.rsp_rdata), 64'(holdRdata));
            checkOutput("rsp_err_hold",    64'(bus.rsp_err),   64'(holdErr));
        end
    end

    // APB slave model: replays the planned number of wait states per transfer.
    always @(negedge PCLK) begin
        if (PRESET) begin
            bus.PREADY  = 1'b0;
            bus.PSLVERR = 1'b0;
            bus.PRDATA  = '0;
            accessN     = 0;
        end else if (bus.PSEL && !bus.PENABLE) begin
            if (planQ.size() > 0) begin
                slvPlan = planQ.pop_front();
            end else begin
                slvPlan.w     = 0;
                slvPlan.rdata = '0;
                slvPlan.err   = 1'b0;
            end
            accessN     = 0;
            bus.PREADY  = 1'($urandom_range(0, 1));
            bus.PSLVERR = 1'($urandom_range(0, 1));
            bus.PRDATA  = $urandom;
        end else if (bus.PSEL && bus.PENABLE) begin
            if (accessN >= slvPlan.w) begin
                bus.PREADY  = 1'b1;
                bus.PRDATA  = slvPlan.rdata;
                bus.PSLVERR = slvPlan.err;
            end else begin
                bus.PREADY  = 1'b0;
                bus.PRDATA  = $urandom;
                bus.PSLVERR = 1'($urandom_range(0, 1));
            end
            accessN++;
        end else begin
            bus.PREADY  = 1'($urandom_range(0, 1));
            bus.PSLVERR = 1'($urandom_range(0, 1));
            bus.PRDATA  = $urandom;
        end
    end

    initial begin
        int          expOrder[4] = '{0, 1, 0, 1};
        int unsigned w;
        int unsigned sel;

        bus.req_valid = 2'b00;
        bus.req_write = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        doReset();

        // Single read, zero wait states, response three cycles after accept
        applyStimulus(2'b01, 2'b00, 16'h0010, 64'h0, 0, 32'hDEADBEEF, 1'b0);
        idleCycles(4);

        // Both requesters held high after reset alternate 0,1,0,1
        doReset();
        grantLog.delete();
        repeat (11) applyStimulus(2'b11, 2'($urandom), 16'($urandom), {$urandom, $urandom},
                                  0, $urandom, 1'b0);
        drain();
        checkOutput("grant_count", 64'(grantLog.size() >= 4), 64'(1));
        for (int i = 0; i < 4; i++) begin
            if (i < grantLog.size())
                checkOutput("grant_order", 64'(grantLog[i]), 64'(expOrder[i]));
        end

        // Write from requester 1 with three wait states and a slave error
        applyStimulus(2'b10, 2'b10, 16'h4433, 64'hCAFEF00D_12345678, 3, 32'h55AA55AA, 1'b1);
        drain();

        // PREADY stuck low: terminated after TIMEOUT cycles, then accepts again
        applyStimulus(2'b01, 2'b00, 16'h0021, 64'h0, 1000, 32'h13572468, 1'b0);
        drain();
        applyStimulus(2'b01, 2'b00, 16'h0022, 64'h0, 1, 32'h24681357, 1'b0);
        drain();

        // Reset in the middle of ACCESS aborts silently; next tie goes to requester 0
        applyStimulus(2'b01, 2'b00, 16'h0030, 64'h0, 1000, 32'h11111111, 1'b0);
        idleCycles(4);
        doReset();
        grantLog.delete();
        applyStimulus(2'b11, 2'b00, 16'h5040, {$urandom, $urandom}, 0, 32'h22222222, 1'b0);
        drain();
        checkOutput("grant_after_reset", 64'(grantLog.size() == 1 && grantLog[0] == 0), 64'(1));

        // Randomised traffic, including timeouts and request toggling while busy
        repeat (400) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)      w = $urandom_range(0, 3);
            else if (sel < 8) w = $urandom_range(4, 15);
            else              w = $urandom_range(16, 20);
            applyStimulus(2'($urandom), 2'($urandom), 16'($urandom), {$urandom, $urandom},
                          w, $urandom, 1'($urandom_range(0, 1)));
        end
        drain();
        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
